// File: rtl/coin_stream_tx_if.sv
// coin_stream_tx_if: valid/ready coin-event handshake between the coin mech and the serial transmitter
interface coin_stream_tx_if;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic       coin_ready;
  modport master(output coin_valid, coin_code, input coin_ready);
  modport slave(input coin_valid, coin_code, output coin_ready);
endinterface

// File: rtl/coin_stream_tx.sv
// coin_stream_tx: buffers coin events in a FIFO and serializes each one as a 5-bit frame on a
module coin_stream_tx #(
  parameter int DEPTH      = 4,
  parameter int BIT_CYCLES = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  coin_stream_tx_if.slave              cin,
  output logic                         a,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         bad_coin,
  output logic [7:0]                   frame_cnt
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int BW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, START, D1, D0, PAR, STOP} state_t;
  state_t        state;
  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [BW-1:0] bit_cnt;
  logic [1:0]    code;
  logic          take, push, last, pop;
  always_comb begin
    cin.coin_ready = !RST && fifo_count != CW'(DEPTH);
    take           = cin.coin_valid && cin.coin_ready;
    push           = take && cin.coin_code != 2'b00;
    last           = bit_cnt == BW'(BIT_CYCLES - 1);
    pop            = fifo_count != '0 && (state == IDLE || (state == STOP && last));
    busy           = state != IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      a          <= 1'b0;
      wp         <= '0;
      rp         <= '0;
      fifo_count <= '0;
      bad_coin   <= 1'b0;
      frame_cnt  <= '0;
      bit_cnt    <= '0;
      code       <= '0;
    end else begin
      bad_coin   <= take && cin.coin_code == 2'b00;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (push) begin
        mem[wp] <= cin.coin_code;
        wp      <= wp + 1'b1;
      end
      if (pop) begin
        code <= mem[rp];
        rp   <= rp + 1'b1;
      end
      if (state != IDLE)
        bit_cnt <= last ? '0 : bit_cnt + 1'b1;
      // IDLE leaves on a pop; every other state advances when its bit time expires
      if (state == IDLE ? pop : last) begin
        case (state)
          IDLE, STOP: begin
            state <= pop ? START : IDLE;
            a     <= pop;
          end
          START: begin
            state <= D1;
            a     <= code[1];
          end
          D1: begin
            state <= D0;
            a     <= code[0];
          end
          D0: begin
            state <= PAR;
            a     <= ^code;
          end
          PAR: begin
            state <= STOP;
            a     <= 1'b0;
          end
          default: begin
            state <= IDLE;
            a     <= 1'b0;
          end
        endcase
        if (state == STOP)
          frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_coin_stream_tx.sv
// tb_coin_stream_tx: scoreboard bench; accepted coins queue expected frames, a monitor decodes a
module tb_coin_stream_tx;
  localparam int DEPTH = 4;
  localparam int BC    = 2;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       a, busy, bad_coin;
  logic [2:0] fifo_count;
  logic [7:0] frame_cnt;
  coin_stream_tx_if cif();
  coin_stream_tx #(.DEPTH(DEPTH), .BIT_CYCLES(BC)) dut (
    .CLK(CLK), .RST(RST), .cin(cif.slave), .a(a), .busy(busy),
    .fifo_count(fifo_count), .bad_coin(bad_coin), .frame_cnt(frame_cnt)
  );
  always #5 CLK = ~CLK;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] exp_q[$];
  bit         in_frame = 0;
  int         pos = 0;
  int         gaps = 0;
  int         peak = 0;
  int         stalls = 0;
  logic [31:0] rx;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] pat(input logic [1:0] c);
    logic [4:0]  b;
    logic [31:0] p;
    b = {1'b1, c[1], c[0], c[1] ^ c[0], 1'b0};
    p = '0;
    for (int i = 4; i >= 0; i--)
      for (int j = 0; j < BC; j++)
        p = {p[30:0], b[i]};
    return p;
  endfunction
  always @(negedge CLK) begin
    if (RST) begin
      in_frame = 0;
      exp_q.delete();
    end else begin
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (!in_frame && a === 1'b1) begin
        in_frame = 1;
        pos = 0;
        rx = '0;
      end else if (!in_frame && exp_q.size() > 0)
        gaps++;
      if (in_frame) begin
        rx = {rx[30:0], a};
        pos++;
        if (pos == 5 * BC) begin
          in_frame = 0;
          if (exp_q.size() == 0) check("sb_extra_frame", 1, 0);
          else check("frame", rx, pat(exp_q.pop_front()));
        end
      end
    end
  end
  task automatic send(input logic [1:0] code);
    int   n;
    logic rdy;
    n = 0;
    cif.coin_valid = 1'b1;
    cif.coin_code  = code;
    do begin
      @(negedge CLK);
      rdy = cif.coin_ready;
      if (!rdy) stalls++;
      @(posedge CLK);
      #1;
      n++;
    end while (!rdy && n < 500);
    if (!rdy) check("send_timeout", 0, 1);
    else if (code != 2'b00) exp_q.push_back(code);
  endtask
  task automatic release_bus();
    cif.coin_valid = 1'b0;
    cif.coin_code  = 2'b00;
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || fifo_count != 0) && n < 5000) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (n >= 5000) check("idle_timeout", 0, 1);
    repeat (2) @(posedge CLK);
    #1;
  endtask
  task automatic tick(input int k);
    repeat (k) @(posedge CLK);
    #1;
  endtask
  initial begin
    release_bus();
    @(negedge CLK);
    check("ready_in_reset", cif.coin_ready, 0);
    tick(2);
    RST = 1'b0;
    #1;
    check("rst_a", a, 0);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_frames", frame_cnt, 0);
    check("rst_bad", bad_coin, 0);
    check("rst_ready", cif.coin_ready, 1);
    // single quarter: latency and frame duration
    send(2'b11);
    release_bus();
    check("q_a_e0", a, 0);
    check("q_count_e0", fifo_count, 1);
    check("q_busy_e0", busy, 0);
    tick(1);
    check("q_a_e1", a, 1);
    check("q_busy_e1", busy, 1);
    tick(5 * BC - 1);
    check("q_busy_last", busy, 1);
    check("q_frames_last", frame_cnt, 0);
    tick(1);
    check("q_busy_done", busy, 0);
    check("q_a_done", a, 0);
    check("q_frames", frame_cnt, 1);
    // nickel then dime back-to-back
    gaps = 0;
    peak = 0;
    send(2'b01);
    send(2'b10);
    release_bus();
    wait_idle();
    check("nd_frames", frame_cnt, 3);
    check("nd_peak", peak, 1);
    check("nd_gaps", gaps, 1);
    // fill the FIFO
    peak = 0;
    stalls = 0;
    send(2'b10); send(2'b11); send(2'b01);
    send(2'b10); send(2'b11); send(2'b01);
    release_bus();
    wait_idle();
    check("fill_peak", peak, DEPTH);
    check("fill_stalled", stalls > 0, 1);
    check("fill_frames", frame_cnt, 9);
    // illegal code
    send(2'b00);
    release_bus();
    check("bad_pulse", bad_coin, 1);
    check("bad_count", fifo_count, 0);
    tick(1);
    check("bad_clear", bad_coin, 0);
    check("bad_a", a, 0);
    check("bad_busy", busy, 0);
    check("bad_frames", frame_cnt, 9);
    // reset during D0 of a quarter with two coins queued
    send(2'b11);
    send(2'b01);
    send(2'b10);
    release_bus();
    tick(3);
    check("mid_a_d0", a, 1);
    check("mid_count", fifo_count, 2);
    RST = 1'b1;
    #1;
    check("mid_ready_rst", cif.coin_ready, 0);
    tick(1);
    check("mid_a", a, 0);
    check("mid_count_rst", fifo_count, 0);
    check("mid_busy", busy, 0);
    check("mid_frames", frame_cnt, 0);
    RST = 1'b0;
    #1;
    check("mid_ready_rel", cif.coin_ready, 1);
    // frame_cnt wrap
    for (int i = 0; i < 255; i++) send(2'b01);
    release_bus();
    wait_idle();
    check("wrap_255", frame_cnt, 255);
    send(2'b01);
    release_bus();
    wait_idle();
    check("wrap_0", frame_cnt, 0);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
